// File: rtl/jk_fsm_bank.sv
// jk_fsm_bank: N independent JK on/off FSMs with request qualification, rise/fall pulses, on-count.
// out changes on the QUAL-th consecutive qualified edge; no backpressure, inputs sampled every cycle.
module jk_fsm_bank #(
  parameter  int N    = 4,
  parameter  int QUAL = 3,
  localparam int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic [N-1:0]  j,
  input  logic [N-1:0]  k,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  clr,
  output logic [N-1:0]  out,
  output logic [N-1:0]  rise,
  output logic [N-1:0]  fall,
  output logic [CW-1:0] on_count
);

  localparam int CNTW = (QUAL > 1) ? $clog2(QUAL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(QUAL - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_ARM    = 2'd1,
    S_ON     = 2'd2,
    S_DISARM = 2'd3
  } state_t;

  state_t          state     [N];
  state_t          state_nxt [N];
  logic [CNTW-1:0] cnt       [N];
  logic [CNTW-1:0] cnt_nxt   [N];
  logic [N-1:0]    out_nxt;
  logic [N-1:0]    want_on;
  logic [N-1:0]    want_off;

  // j&k resolution: toggle mode lets it act from either side, dominance modes from one side only.
  assign want_on  = j & (~k | {N{(mode == 2'b01) || (mode == 2'b10)}});
  assign want_off = k & (~j | {N{(mode == 2'b01) || (mode == 2'b11)}});

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      if (clr[i]) begin
        state_nxt[i] = S_OFF;
        cnt_nxt[i]   = '0;
      end else begin
        case (state[i])
          S_OFF: begin
            if (want_on[i]) begin
              if (QUAL == 1) begin
                state_nxt[i] = S_ON;
              end else begin
                state_nxt[i] = S_ARM;
                cnt_nxt[i]   = CNTW'(1);
              end
            end
          end
          S_ARM: begin
            if (!want_on[i]) begin
              state_nxt[i] = S_OFF;
              cnt_nxt[i]   = '0;
            end else if (cnt[i] == CNT_LAST) begin
              state_nxt[i] = S_ON;
              cnt_nxt[i]   = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + CNTW'(1);
            end
          end
          S_ON: begin
            if (want_off[i]) begin
              if (QUAL == 1) begin
                state_nxt[i] = S_OFF;
              end else begin
                state_nxt[i] = S_DISARM;
                cnt_nxt[i]   = CNTW'(1);
              end
            end
          end
          S_DISARM: begin
            if (!want_off[i]) begin
              state_nxt[i] = S_ON;
              cnt_nxt[i]   = '0;
            end else if (cnt[i] == CNT_LAST) begin
              state_nxt[i] = S_OFF;
              cnt_nxt[i]   = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + CNTW'(1);
            end
          end
          default: begin
            state_nxt[i] = S_OFF;
            cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    out_nxt = '0;
    out     = '0;
    for (int i = 0; i < N; i++) begin
      out_nxt[i] = (state_nxt[i] == S_ON) || (state_nxt[i] == S_DISARM);
      out[i]     = (state[i] == S_ON) || (state[i] == S_DISARM);
    end
  end

  // Pulses are registered alongside state so they line up with the out edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N; i++) begin
        state[i] <= S_OFF;
        cnt[i]   <= '0;
      end
      rise <= '0;
      fall <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      rise <= out_nxt & ~out;
      fall <= ~out_nxt & out;
    end
  end

  always_comb begin
    on_count = '0;
    for (int i = 0; i < N; i++) begin
      on_count = on_count + CW'(out[i]);
    end
  end

endmodule

// File: tb/tb_jk_fsm_bank.sv
// Bench for jk_fsm_bank: QUAL=3 and QUAL=1 instances against a streak-counting model plus literal checks.
module tb_jk_fsm_bank;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [3:0] j = '0, k = '0, clr = '0;
  logic [1:0] mode = '0;
  logic [3:0] j1 = '0, k1 = '0, clr1 = '0;
  logic [1:0] mode1 = '0;
  logic [3:0] out, rise, fall, out1, rise1, fall1;
  logic [2:0] on_count, on_count1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  jk_fsm_bank #(.N(4), .QUAL(3)) dut (
    .clk(clk), .areset(areset), .j(j), .k(k), .mode(mode), .clr(clr),
    .out(out), .rise(rise), .fall(fall), .on_count(on_count)
  );

  jk_fsm_bank #(.N(4), .QUAL(1)) dut1 (
    .clk(clk), .areset(areset), .j(j1), .k(k1), .mode(mode1), .clr(clr1),
    .out(out1), .rise(rise1), .fall(fall1), .on_count(on_count1)
  );

  // Model: a channel flips after its relevant request has been seen on QUAL consecutive edges.
  logic [3:0] m_out  [2] = '{4'b0, 4'b0};
  logic [3:0] m_rise [2] = '{4'b0, 4'b0};
  logic [3:0] m_fall [2] = '{4'b0, 4'b0};
  int         m_run  [2][4];

  function automatic logic flip_req(input logic cur, input logic jb, input logic kb,
                                    input logic [1:0] md);
    if (jb && kb) begin
      case (md)
        2'b00:   return 1'b0;
        2'b01:   return 1'b1;
        2'b10:   return !cur;
        default: return cur;
      endcase
    end
    return cur ? kb : jb;
  endfunction

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int d = 0; d < 2; d++) begin
        m_out[d] = '0; m_rise[d] = '0; m_fall[d] = '0;
        for (int i = 0; i < 4; i++) m_run[d][i] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        automatic int         q  = (d == 0) ? 3 : 1;
        automatic logic [3:0] jv = (d == 0) ? j : j1;
        automatic logic [3:0] kv = (d == 0) ? k : k1;
        automatic logic [3:0] cv = (d == 0) ? clr : clr1;
        automatic logic [1:0] mv = (d == 0) ? mode : mode1;
        automatic logic [3:0] nxt = m_out[d];
        for (int i = 0; i < 4; i++) begin
          if (cv[i]) begin
            nxt[i] = 1'b0;
            m_run[d][i] = 0;
          end else if (flip_req(m_out[d][i], jv[i], kv[i], mv)) begin
            m_run[d][i] = m_run[d][i] + 1;
            if (m_run[d][i] == q) begin
              nxt[i] = ~m_out[d][i];
              m_run[d][i] = 0;
            end
          end else begin
            m_run[d][i] = 0;
          end
        end
        m_rise[d] = nxt & ~m_out[d];
        m_fall[d] = ~nxt & m_out[d];
        m_out[d]  = nxt;
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("out", out, m_out[0]);
    chk("rise", rise, m_rise[0]);
    chk("fall", fall, m_fall[0]);
    chk("on_count", {1'b0, on_count}, 4'($countones(m_out[0])));
    chk("out_q1", out1, m_out[1]);
    chk("rise_q1", rise1, m_rise[1]);
    chk("fall_q1", fall1, m_fall[1]);
    chk("on_count_q1", {1'b0, on_count1}, 4'($countones(m_out[1])));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    chk("lit_reset_out", out, 4'b0000);
    chk("lit_reset_cnt", {1'b0, on_count}, 4'd0);
    areset = 1'b0;

    // short request: two edges then drop
    j = 4'b0001; step(2); j = 4'b0000; step(1);
    chk("lit_short_out", out, 4'b0000);
    chk("lit_short_rise", rise, 4'b0000);

    // full qualification on channel 0
    j = 4'b0001; step(2);
    chk("lit_q2_out", out, 4'b0000);
    step(1);
    chk("lit_q3_out", out, 4'b0001);
    chk("lit_q3_rise", rise, 4'b0001);
    chk("lit_q3_cnt", {1'b0, on_count}, 4'd1);
    j = 4'b0000; step(1);
    chk("lit_rise_once", rise, 4'b0000);

    // channel 1: hold then toggle
    j = 4'b0010; step(3);
    chk("lit_ch1_on", out, 4'b0011);
    k = 4'b0010; step(5);
    chk("lit_hold_mode", out, 4'b0011);
    mode = 2'b01; step(2);
    chk("lit_tog_wait", out, 4'b0011);
    step(1);
    chk("lit_tog_off", out, 4'b0001);
    chk("lit_tog_fall", fall, 4'b0010);
    step(3);
    chk("lit_tog_on", out, 4'b0011);
    chk("lit_tog_rise", rise, 4'b0010);
    j = '0; k = '0; mode = 2'b00; step(1);

    // dominance on channel 2
    j = 4'b0100; step(3);
    chk("lit_ch2_on", out, 4'b0111);
    mode = 2'b10; k = 4'b0100; step(4);
    chk("lit_setdom", out, 4'b0111);
    j = 4'b0000; mode = 2'b00; step(3);
    chk("lit_ch2_off", out, 4'b0011);
    mode = 2'b11; j = 4'b0100; step(4);
    chk("lit_rstdom", out, 4'b0011);
    j = '0; k = '0; mode = 2'b00; step(1);

    // async reset with channel 3 mid-disarm
    j = 4'b1000; step(3);
    chk("lit_ch3_on", out, 4'b1011);
    j = 4'b0000; k = 4'b1000; step(2);
    chk("lit_disarm", out, 4'b1011);
    #3 areset = 1'b1;
    #1;
    chk("lit_ar_out", out, 4'b0000);
    chk("lit_ar_rise", rise, 4'b0000);
    chk("lit_ar_fall", fall, 4'b0000);
    chk("lit_ar_cnt", {1'b0, on_count}, 4'd0);
    #1 areset = 1'b0; k = 4'b0000;
    step(3);
    chk("lit_ar_after", out, 4'b0000);

    // all on, then clear
    j = 4'b1111; step(3);
    chk("lit_all_on", out, 4'b1111);
    chk("lit_all_cnt", {1'b0, on_count}, 4'd4);
    j = 4'b0000; clr = 4'b0101; step(1);
    chk("lit_clr_out", out, 4'b1010);
    chk("lit_clr_fall", fall, 4'b0101);
    chk("lit_clr_cnt", {1'b0, on_count}, 4'd2);
    clr = 4'b0000; step(1);
    chk("lit_clr_fall_once", fall, 4'b0000);

    // clr beats a request qualifying on the same edge
    j = 4'b0001; step(2);
    clr = 4'b0001; step(1);
    chk("lit_clr_wins", out, 4'b1010);
    chk("lit_clr_norise", rise, 4'b0000);
    clr = '0; j = '0; step(1);
    chk("lit_clr_after", out, 4'b1010);

    // QUAL=1 instance: single-edge JK response
    j1 = 4'b0001; step(1);
    chk("lit_q1_on", out1, 4'b0001);
    chk("lit_q1_rise", rise1, 4'b0001);
    j1 = 4'b0000; k1 = 4'b0001; step(1);
    chk("lit_q1_off", out1, 4'b0000);
    chk("lit_q1_fall", fall1, 4'b0001);
    mode1 = 2'b01; j1 = 4'b0001; step(1);
    chk("lit_q1_tog1", out1, 4'b0001);
    step(1);
    chk("lit_q1_tog2", out1, 4'b0000);
    j1 = '0; k1 = '0; mode1 = 2'b00; step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
